// File: rtl/sram_rw_arbiter.sv
// Single-port SRAM front end: sweeps the array to zero after reset or init_req,
// then arbitrates one read or write per cycle with a 1-entry read response buffer.
module sram_rw_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init_req,
  output logic              init_done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic                prio_rd_q, prio_rd_d;
  logic                init_done_q, init_done_d;
  logic                rd_pend_q, rd_pend_d;
  logic                hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;

  logic run_ok;
  logic slot_free;
  logic rd_gnt;
  logic wr_gnt;

  always_comb begin
    // Fresh read data comes straight from the SRAM; afterwards from the hold copy.
    resp_valid = rd_pend_q | hold_vld_q;
    resp_data  = rd_pend_q ? sram_rdata : hold_data_q;
    slot_free  = ~resp_valid | resp_ready;
    run_ok     = (state_q == RUN) & ~init_req;

    // Each ready reflects whether that channel would win, using only the other valid.
    rd_ready   = run_ok & slot_free & (~wr_valid | prio_rd_q);
    wr_ready   = run_ok & (~(rd_valid & slot_free) | ~prio_rd_q);
    rd_gnt     = rd_valid & rd_ready;
    wr_gnt     = wr_valid & wr_ready;

    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (state_q == INIT) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_cnt_q;
    end else if (wr_gnt) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = wr_addr;
      sram_wdata = wr_data;
    end else if (rd_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = rd_addr;
    end

    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prio_rd_d  = prio_rd_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_ADDR) begin
        state_d    = RUN;
        init_cnt_d = '0;
      end
    end else if (init_req) begin
      state_d    = INIT;
      init_cnt_d = '0;
    end else if (wr_gnt) begin
      prio_rd_d = 1'b1;
    end else if (rd_gnt) begin
      prio_rd_d = 1'b0;
    end

    init_done_d = (state_d == RUN);
    rd_pend_d   = rd_gnt;
    hold_vld_d  = resp_valid & ~resp_ready;
    hold_data_d = rd_pend_q ? sram_rdata : hold_data_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      prio_rd_q   <= 1'b1;
      init_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      prio_rd_q   <= prio_rd_d;
      init_done_q <= init_done_d;
      rd_pend_q   <= rd_pend_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter: SRAM model, directed vector table, hand sequences
// and a randomized run checked against a transaction-level reference model.
module tb_sram_rw_arbiter;

  localparam int AW = 7;
  localparam int DW = 16;
  localparam int DEPTH = 128;

  logic          clock = 1'b0;
  logic          reset, init_req, init_done;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, sram_addr;
  logic [DW-1:0] wr_data, resp_data, sram_wdata, sram_rdata;
  logic          resp_valid, resp_ready, sram_en, sram_wmode;

  sram_rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .init_req(init_req), .init_done(init_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata));

  initial forever #5 clock = ~clock;

  // Behavioural SRAM: never-written cells read back as non-zero garbage.
  logic [DW-1:0] mem [DEPTH];
  bit            mem_set [DEPTH];
  always @(posedge clock) begin
    if (sram_en === 1'b1) begin
      if (sram_wmode) begin
        mem[sram_addr]     <= sram_wdata;
        mem_set[sram_addr] <= 1'b1;
      end else begin
        sram_rdata <= mem_set[sram_addr] ? mem[sram_addr] : (16'hD000 | 16'(sram_addr));
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clear sweep progress, who has priority, expected responses, memory image.
  bit            m_clearing;
  int            m_clear_idx;
  bit            m_prio_read;
  logic [DW-1:0] m_resp_q[$];
  logic [DW-1:0] m_shadow [DEPTH];
  bit            m_rg, m_wg;

  // 0 = nobody, 1 = read wins, 2 = write wins
  function automatic int winner(input bit r, input bit w);
    if (r && w) return m_prio_read ? 1 : 2;
    if (r) return 1;
    if (w) return 2;
    return 0;
  endfunction

  task automatic drive(input bit rv, input int ra, input bit wv, input int wa,
                       input int wd, input bit rr, input bit ir);
    rd_valid = rv; rd_addr = AW'(ra); wr_valid = wv; wr_addr = AW'(wa);
    wr_data = DW'(wd); resp_ready = rr; init_req = ir;
  endtask

  task automatic settle();
    bit slot_free, er, ew;
    #4;
    m_rg = 0; m_wg = 0;
    if (reset === 1'b1) begin
      if (m_clearing) begin
        chk("m_init_done", init_done, 0);
        chk("m_rd_ready", rd_ready, 0);
        chk("m_wr_ready", wr_ready, 0);
        chk("m_clr_en", sram_en, 1);
        chk("m_clr_wmode", sram_wmode, 1);
        chk("m_clr_addr", sram_addr, m_clear_idx);
        chk("m_clr_wdata", sram_wdata, 0);
      end else begin
        chk("m_init_done", init_done, 1);
        if (init_req) begin
          chk("m_rd_ready", rd_ready, 0);
          chk("m_wr_ready", wr_ready, 0);
          chk("m_en", sram_en, 0);
        end else begin
          slot_free = (m_resp_q.size() == 0) || resp_ready;
          er = (winner(slot_free, wr_valid) == 1);
          ew = (winner(rd_valid && slot_free, 1'b1) == 2);
          chk("m_rd_ready", rd_ready, er);
          chk("m_wr_ready", wr_ready, ew);
          m_rg = rd_valid && er;
          m_wg = wr_valid && ew;
          chk("m_en", sram_en, m_rg || m_wg);
          if (m_wg) begin
            chk("m_wr_wmode", sram_wmode, 1);
            chk("m_wr_addr", sram_addr, wr_addr);
            chk("m_wr_wdata", sram_wdata, wr_data);
          end
          if (m_rg) begin
            chk("m_rd_wmode", sram_wmode, 0);
            chk("m_rd_addr", sram_addr, rd_addr);
          end
        end
      end
      chk("m_resp_valid", resp_valid, m_resp_q.size() != 0);
      if (m_resp_q.size() != 0) chk("m_resp_data", resp_data, m_resp_q[0]);
    end
  endtask

  task automatic advance();
    @(posedge clock);
    if (reset !== 1'b1) begin
      m_clearing = 1; m_clear_idx = 0; m_prio_read = 1;
      m_resp_q.delete();
      foreach (m_shadow[i]) m_shadow[i] = '0;
    end else begin
      if (m_resp_q.size() != 0 && resp_ready) void'(m_resp_q.pop_front());
      if (m_clearing) begin
        m_clear_idx++;
        if (m_clear_idx == DEPTH) begin m_clearing = 0; m_clear_idx = 0; end
      end else if (init_req) begin
        m_clearing = 1; m_clear_idx = 0;
        foreach (m_shadow[i]) m_shadow[i] = '0;
      end else begin
        if (m_wg) begin m_shadow[wr_addr] = wr_data; m_prio_read = 1; end
        if (m_rg) begin m_resp_q.push_back(m_shadow[rd_addr]); m_prio_read = 0; end
      end
    end
    #1;
  endtask

  // Counts clear cycles (init_done low) until init_done rises; leaves us mid-cycle.
  task automatic wait_init(output int n);
    n = 0;
    drive(0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("clear_start_addr", sram_addr, 0);
    while (init_done !== 1'b1 && n < 300) begin
      n++;
      advance();
      settle();
    end
  endtask

  typedef struct {
    bit rv; int ra; bit wv; int wa; int wd; bit rr; bit ir;
    bit e_rr; bit e_wr; bit e_done; bit e_rv; logic [DW-1:0] e_rd;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit rv, input int ra, input bit wv, input int wa,
                              input int wd, input bit rr, input bit ir, input bit e_rr,
                              input bit e_wr, input bit e_rv, input logic [DW-1:0] e_rd);
    vec_t v;
    v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd; v.rr = rr; v.ir = ir;
    v.e_rr = e_rr; v.e_wr = e_wr; v.e_done = 1; v.e_rv = e_rv; v.e_rd = e_rd;
    tbl.push_back(v);
  endfunction

  initial begin
    int n;
    //   rv ra  wv wa  wd       rr ir  e_rr e_wr e_rv e_rd
    // Both requesters busy: read first, then alternate; write@T visible to read@T+1.
    add(1, 5,  1, 7,  'hBEEF, 1, 0,  1, 0, 0, 16'h0000);
    add(1, 5,  1, 7,  'hBEEF, 1, 0,  0, 1, 1, 16'h0000);
    add(1, 7,  1, 7,  'hBEEF, 1, 0,  1, 0, 0, 16'h0000);
    add(1, 7,  1, 7,  'hBEEF, 1, 0,  0, 1, 1, 16'hBEEF);
    // Write 0x1234 to 3, read it back next cycle.
    add(0, 0,  1, 3,  'h1234, 1, 0,  1, 1, 0, 16'h0000);
    add(1, 3,  0, 0,  0,      1, 0,  1, 0, 0, 16'h0000);
    add(0, 0,  0, 0,  0,      1, 0,  1, 1, 1, 16'h1234);
    // Stalled response on 7 while 7 is overwritten with zero.
    add(1, 7,  0, 0,  0,      0, 0,  1, 1, 0, 16'h0000);
    for (int i = 0; i < 5; i++)
      add(1, 7, 1, 7, 0,      0, 0,  0, 1, 1, 16'hBEEF);
    add(1, 7,  0, 0,  0,      1, 0,  1, 0, 1, 16'hBEEF);
    add(0, 0,  0, 0,  0,      1, 0,  1, 1, 1, 16'h0000);
    // Write 0xAAAA to 10, then init_req blocks both channels.
    add(0, 0,  1, 10, 'hAAAA, 1, 0,  0, 1, 0, 16'h0000);
    add(1, 10, 1, 10, 'h5555, 1, 1,  0, 0, 0, 16'h0000);

    reset = 0;
    drive(0, 0, 0, 0, 0, 1, 0);
    @(posedge clock); #1;
    repeat (3) begin settle(); advance(); end

    reset = 1;
    wait_init(n);
    chk("first_clear_cycles", n, 128);
    chk("done_after_clear", init_done, 1);
    chk("resp_idle_after_reset", resp_valid, 0);
    advance();

    foreach (tbl[i]) begin
      drive(tbl[i].rv, tbl[i].ra, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rr, tbl[i].ir);
      settle();
      chk($sformatf("tbl%0d_rd_ready", i), rd_ready, tbl[i].e_rr);
      chk($sformatf("tbl%0d_wr_ready", i), wr_ready, tbl[i].e_wr);
      chk($sformatf("tbl%0d_init_done", i), init_done, tbl[i].e_done);
      chk($sformatf("tbl%0d_resp_valid", i), resp_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_resp_data", i), resp_data, tbl[i].e_rd);
      advance();
    end

    wait_init(n);
    chk("reinit_cycles", n, 128);
    advance();
    drive(1, 10, 0, 0, 0, 1, 0);
    settle();
    chk("rd10_ready", rd_ready, 1);
    advance();
    drive(0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("rd10_resp_valid", resp_valid, 1);
    chk("rd10_resp_data", resp_data, 16'h0000);
    advance();

    // Pending response must outlive an init_req.
    drive(0, 0, 1, 3, 'h4321, 1, 0); settle(); advance();
    drive(1, 3, 0, 0, 0, 0, 0); settle(); chk("hold_rd_ready", rd_ready, 1); advance();
    drive(0, 0, 0, 0, 0, 0, 1); settle();
    chk("hold_at_init_req", resp_data, 16'h4321); advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("hold_in_init_valid", resp_valid, 1);
      chk("hold_in_init_data", resp_data, 16'h4321);
      advance();
    end
    drive(0, 0, 0, 0, 0, 1, 0); settle(); advance();
    settle(); chk("hold_retired", resp_valid, 0);

    // Reset in the middle of the sweep restarts from address 0.
    n = 0;
    while (sram_addr !== AW'(60) && n < 200) begin n++; advance(); settle(); end
    chk("reach_addr60", sram_addr, 60);
    reset = 0;
    advance();
    reset = 1;
    wait_init(n);
    chk("restart_clear_cycles", n, 128);
    advance();

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 799) != 0);
      drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
            $urandom_range(0, 15), $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 299) == 0);
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
